// File: rtl/fpnew_f2i_wb_buffer.sv
// fpnew_f2i_wb_buffer
//   Writeback buffer behind the FP-to-int cast unit. Cast results are queued
//   in a DEPTH-entry FIFO, sign-extended to XLEN at the output using the
//   stored extension bit, and the status of every committed (popped) entry is
//   folded into sticky fflags and a saturating NV event counter.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   in_valid_i/in_ready_o upstream handshake (in_ready_o depends on state only)
//   result_i, status_i,
//   extension_bit_i,tag_i entry fields from the cast unit
//   flush_i               discard queued entries and drop any same-cycle push
//   out_valid_o/out_ready_i  writeback handshake for the head entry
//   result_o, status_o, tag_o  head entry (zero while empty)
//   fflags_o, fflags_clr_i     sticky OR of committed status, and its clear
//   nv_count_o            saturating count of committed entries with NV set
//   busy_o                any entry queued
module fpnew_f2i_wb_buffer #(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned DST_WIDTH = 64,
  parameter int unsigned XLEN      = 64,
  parameter int unsigned TAG_WIDTH = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DST_WIDTH-1:0] result_i,
  input  logic [4:0]           status_i,
  input  logic                 extension_bit_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [XLEN-1:0]      result_o,
  output logic [4:0]           status_o,
  output logic [TAG_WIDTH-1:0] tag_o,
  output logic [4:0]           fflags_o,
  input  logic                 fflags_clr_i,
  output logic [CNT_WIDTH-1:0] nv_count_o,
  output logic                 busy_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  // Replicates the extension bit above the cast result; written so that
  // DST_WIDTH == XLEN needs no zero-width replication.
  function automatic logic [XLEN-1:0] sext(input logic [DST_WIDTH-1:0] r,
                                           input logic                 e);
    logic [XLEN-1:0] v;
    v = {XLEN{e}};
    v[DST_WIDTH-1:0] = r;
    return v;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic [DST_WIDTH-1:0] result_mem_q [DEPTH];
  logic [4:0]           status_mem_q [DEPTH];
  logic                 ext_mem_q    [DEPTH];
  logic [TAG_WIDTH-1:0] tag_mem_q    [DEPTH];

  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]     count_q, count_d;
  logic [4:0]           fflags_q, fflags_d;
  logic [CNT_WIDTH-1:0] nv_count_q, nv_count_d;

  logic full, empty, push, pop;
  logic [4:0] head_status;

  assign full        = (count_q == OCC_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign in_ready_o  = ~full;
  assign out_valid_o = ~empty;
  assign busy_o      = ~empty;

  // A push coinciding with flush is dropped; a pop still commits.
  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i;

  assign head_status = status_mem_q[rd_ptr_q];

  assign result_o   = empty ? '0 : sext(result_mem_q[rd_ptr_q], ext_mem_q[rd_ptr_q]);
  assign status_o   = empty ? '0 : head_status;
  assign tag_o      = empty ? '0 : tag_mem_q[rd_ptr_q];
  assign fflags_o   = fflags_q;
  assign nv_count_o = nv_count_q;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    fflags_d   = fflags_q;
    nv_count_d = nv_count_q;

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + OCC_W'(push) - OCC_W'(pop);
    end

    // Clear and commit together keep only the committed status.
    if (fflags_clr_i && pop) fflags_d = head_status;
    else if (fflags_clr_i)   fflags_d = '0;
    else if (pop)            fflags_d = fflags_q | head_status;

    if (pop && head_status[4]) nv_count_d = sat_inc(nv_count_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fflags_q   <= '0;
      nv_count_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fflags_q   <= fflags_d;
      nv_count_q <= nv_count_d;
    end
  end

  // Entry storage carries data only and needs no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      result_mem_q[wr_ptr_q] <= result_i;
      status_mem_q[wr_ptr_q] <= status_i;
      ext_mem_q[wr_ptr_q]    <= extension_bit_i;
      tag_mem_q[wr_ptr_q]    <= tag_i;
    end
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));
  a_valid_count:  assert property (@(posedge clk_i) disable iff (rst_i) out_valid_o == (count_q != '0));
  a_count_range:  assert property (@(posedge clk_i) disable iff (rst_i) count_q <= OCC_W'(DEPTH));

endmodule
